pipelined_barrel_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 13 +
 rtl/pipelined_barrel_shifter_stage.sv | 63 ++++++
 rtl/pipelined_barrel_shifter.sv | 87 ++++++++
 tb/tb_pipelined_barrel_shifter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and mode encodings for the pipelined barrel shifter.
// Imported by the stage slice and the top level.
package shifter_pkg;

    // Operation selector carried alongside every operand in the pipe.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SLL = 2'b00;
    localparam mode_t MODE_SRL = 2'b01;
    localparam mode_t MODE_SRA = 2'b10;
    localparam mode_t MODE_ROR = 2'b11;

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One level of the barrel shifter: conditional shift by DIST,
// followed by the {valid, data, shamt, mode} pipeline register.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int DIST  = 1,
    parameter int BIT   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic [SHW-1:0]   up_shamt,
    input  mode_t            up_mode,
    input  logic             down_accept,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   shamt,
    output mode_t            mode
);

    logic [WIDTH-1:0] shifted;
    logic             accept;

    // The slot frees up when empty or when its content moves on.
    assign accept = !valid || down_accept;

    // Shift by DIST when this level's shamt bit is set.
    always_comb begin
        shifted = up_data;
        if (up_shamt[BIT]) begin
            unique case (up_mode)
                MODE_SLL: shifted = {up_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                MODE_SRL: shifted = {{DIST{1'b0}}, up_data[WIDTH-1:DIST]};
                MODE_SRA: shifted = {{DIST{up_data[WIDTH-1]}},
                                     up_data[WIDTH-1:DIST]};
                MODE_ROR: shifted = {up_data[DIST-1:0],
                                     up_data[WIDTH-1:DIST]};
                default:  shifted = up_data;
            endcase
        end
    end

    // Stage register; payload only reloads when a real op arrives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            mode  <= MODE_SLL;
        end else if (accept) begin
            valid <= up_valid;
            if (up_valid) begin
                data  <= shifted;
                shamt <= up_shamt;
                mode  <= up_mode;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) register stages,
// valid/ready handshake on both sides with full back-pressure.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  mode_t            in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    logic [SHW-1:0]            stage_valid;
    logic [SHW-1:0]            ready_chain;
    logic [SHW-1:0][WIDTH-1:0] stage_data;
    logic [SHW-1:0][SHW-1:0]   stage_shamt;
    mode_t [SHW-1:0]           stage_mode;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        // Stage k can load unless it and every stage after it
        // are full while the consumer stalls; written flat so the
        // chain has no combinational self-reference.
        assign ready_chain[k] = out_ready || !(&stage_valid[SHW-1:k]);

        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic [SHW-1:0]   src_shamt;
        mode_t            src_mode;
        logic             nxt_accept;

        if (k == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_shamt = in_shamt;
            assign src_mode  = in_mode;
        end else begin : g_body
            assign src_valid = stage_valid[k-1];
            assign src_data  = stage_data[k-1];
            assign src_shamt = stage_shamt[k-1];
            assign src_mode  = stage_mode[k-1];
        end

        if (k == SHW - 1) begin : g_tail
            assign nxt_accept = out_ready;
        end else begin : g_mid
            assign nxt_accept = ready_chain[k+1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .DIST  (1 << k),
            .BIT   (k)
        ) u_stage (
            .clock       (clock),
            .reset       (reset),
            .up_valid    (src_valid),
            .up_data     (src_data),
            .up_shamt    (src_shamt),
            .up_mode     (src_mode),
            .down_accept (nxt_accept),
            .valid       (stage_valid[k]),
            .data        (stage_data[k]),
            .shamt       (stage_shamt[k]),
            .mode        (stage_mode[k])
        );
    end

    assign in_ready  = ready_chain[0];
    assign out_valid = stage_valid[SHW-1];
    assign out_data  = stage_data[SHW-1];
    assign out_zero  = ~|stage_data[SHW-1];

    // Tail shamt/mode have no consumer past the last level.
    logic unused_tail;
    assign unused_tail = ^{stage_shamt[SHW-1], stage_mode[SHW-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH 32 and 8,
// with a short random back-pressure run against a reference model.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    mode_t       in_mode;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_out_zero;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_shamt;
    mode_t       b_in_mode;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipelined_barrel_shifter #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_shamt  (b_in_shamt),
        .in_mode   (b_in_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_zero  (b_out_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] model32(input logic [31:0] d,
                                            input logic [4:0] sh,
                                            input mode_t m);
        logic [31:0] r;
        case (m)
            MODE_SLL: r = d << sh;
            MODE_SRL: r = d >> sh;
            MODE_SRA: r = $unsigned($signed(d) >>> sh);
            default:  r = (d >> sh) | (d << (32 - int'(sh)));
        endcase
        return r;
    endfunction

    // Single op: exact latency, result, zero flag, capture at accept.
    task automatic run_one(input string tag, input logic [31:0] d,
                           input logic [4:0] sh, input mode_t m,
                           input logic [31:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = sh;
        in_mode   = m;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        in_data  = ~d;
        in_shamt = ~sh;
        in_mode  = ~m;
        repeat (3) tick;
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        tick;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_zero"}, 32'(out_zero), 32'(exp == 32'd0));
        tick;
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run8(input string tag, input logic [7:0] d,
                        input logic [2:0] sh, input mode_t m,
                        input logic [7:0] exp);
        bit seen;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = d;
        b_in_shamt  = sh;
        b_in_mode   = m;
        tick;
        b_in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (b_out_valid) begin
                seen = 1'b1;
                chk({tag, "_data"}, 32'(b_out_data), 32'(exp));
                chk({tag, "_zero"}, 32'(b_out_zero), 32'(exp == 8'd0));
            end
            tick;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    logic [31:0] bx[10];
    logic [31:0] sx[10];
    logic [31:0] q[$];
    logic [31:0] e;
    int got, first, last, acc, sent, stray;

    initial begin
        reset = 1'b1;
        in_valid = 0; in_data = 0; in_shamt = 0; in_mode = MODE_SLL;
        out_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_in_shamt = 0;
        b_in_mode = MODE_SLL; b_out_ready = 1;
        #12;
        reset = 1'b0;
        tick;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_one("sll31", 32'h00000001, 5'd31, MODE_SLL, 32'h80000000);
        run_one("srl4", 32'h80000000, 5'd4, MODE_SRL, 32'h08000000);
        run_one("sra8n", 32'hF0000000, 5'd8, MODE_SRA, 32'hFFF00000);
        run_one("sra31", 32'h80000000, 5'd31, MODE_SRA, 32'hFFFFFFFF);
        run_one("sra8p", 32'h70000000, 5'd8, MODE_SRA, 32'h00700000);
        run_one("ror8", 32'h12345678, 5'd8, MODE_ROR, 32'h78123456);
        run_one("ror0", 32'h12345678, 5'd0, MODE_ROR, 32'h12345678);
        run_one("sll0", 32'h00000001, 5'd0, MODE_SLL, 32'h00000001);
        run_one("srl_zero", 32'h0000000F, 5'd4, MODE_SRL, 32'h00000000);
        run_one("ror31", 32'h80000001, 5'd31, MODE_ROR, 32'h00000003);

        // Back-to-back burst, consumer always ready.
        out_ready = 1'b1;
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 10) begin
                in_valid = 1'b1;
                in_data  = 32'hA5A50000 + 32'(c * 32'h1111);
                in_shamt = 5'(c * 3);
                in_mode  = mode_t'(c % 4);
                bx[c] = model32(in_data, in_shamt, in_mode);
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                if (got < 10) chk("burst_data", out_data, bx[got]);
                if (first < 0) first = c;
                last = c;
                got++;
            end
            tick;
        end
        chk("burst_count", 32'(got), 32'd10);
        chk("burst_consecutive", 32'(last - first), 32'd9);

        // Stall: fill the pipe with the consumer blocked.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (!in_ready) break;
            in_valid = 1'b1;
            in_data  = 32'h00000011 * 32'(acc + 1);
            in_shamt = 5'(acc + 1);
            in_mode  = MODE_SLL;
            sx[acc] = model32(in_data, in_shamt, in_mode);
            tick;
            acc++;
        end
        chk("stall_accepted", 32'(acc), 32'd5);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_head", out_data, sx[0]);
        for (int i = 0; i < 3; i++) begin
            in_data  = 32'hDEAD0000 + 32'(i);
            in_shamt = 5'(7 + i);
            in_mode  = MODE_ROR;
            tick;
        end
        chk("stall_hold", out_data, sx[0]);
        chk("stall_still_full", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                if (got < 5) chk("stall_order", out_data, sx[got]);
                got++;
            end
            tick;
        end
        chk("stall_count", 32'(got), 32'd5);

        // Asynchronous reset in the middle of a burst.
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h0F0F0F0F;
            in_shamt = 5'(c);
            in_mode  = MODE_ROR;
            tick;
        end
        in_valid = 1'b0;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_zero", 32'(out_zero), 32'd1);
        #3;
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (out_valid) stray++;
        end
        chk("mid_no_stale", 32'(stray), 32'd0);

        // Random traffic and back-pressure against the model.
        sent = 0;
        q.delete();
        for (int c = 0; c < 4000 && (sent < 400 || q.size() > 0); c++) begin
            in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_shamt  = 5'($urandom);
            in_mode   = mode_t'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_extra", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rand_data", out_data, e);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model32(in_data, in_shamt, in_mode));
                sent++;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        chk("rand_sent", 32'(sent), 32'd400);
        chk("rand_left", 32'(q.size()), 32'd0);

        // Narrow instance.
        run8("w8_sra7", 8'h80, 3'd7, MODE_SRA, 8'hFF);
        run8("w8_ror1", 8'h81, 3'd1, MODE_ROR, 8'hC0);
        run8("w8_sll3", 8'h01, 3'd3, MODE_SLL, 8'h08);
        run8("w8_srl4", 8'hF0, 3'd4, MODE_SRL, 8'h0F);
        run8("w8_ror4", 8'h12, 3'd4, MODE_ROR, 8'h21);
        run8("w8_zero", 8'h0F, 3'd4, MODE_SRL, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
